// File: rtl/cs_uarch_pkg.sv
// ---------------------------------------------------------------------------
// cs_uarch_pkg
// Shared microarchitecture definitions for the microprogrammed control unit:
// MIR field widths, COND encodings, sequencer FSM states, the MIR field
// bundle seen by the sequencer, and the dispatch address helper.
// ---------------------------------------------------------------------------
package cs_uarch_pkg;

   localparam int unsigned ADDR_W   = 11;
   localparam int unsigned COND_W   = 3;
   localparam int unsigned OPCODE_W = 8;

   typedef enum logic [COND_W-1:0] {
      COND_NEXT     = 3'd0,
      COND_JN       = 3'd1,
      COND_JZ       = 3'd2,
      COND_JMP      = 3'd3,
      COND_DISPATCH = 3'd4,
      COND_CALL     = 3'd5,
      COND_RET      = 3'd6,
      COND_HALT     = 3'd7
   } condE;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } stateE;

   // MIR fields consumed by the sequencer
   typedef struct packed {
      condE              cond;
      logic [ADDR_W-1:0] address;
      logic              rd;
      logic              wr;
   } mirSeqFieldsT;

   // Dispatch keeps the page bits of ADDRESS and replaces the rest with OPCODE
   function automatic logic [ADDR_W-1:0] dispatchTarget(
      input logic [ADDR_W-1:0]   address,
      input logic [OPCODE_W-1:0] opcode
   );
      return {address[ADDR_W-1:OPCODE_W], opcode};
   endfunction

endpackage

// File: rtl/cs_seq_stack.sv
// ---------------------------------------------------------------------------
// cs_seq_stack
// LIFO of micro-return addresses.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset (pointer only)
//   push, pop        one-cycle requests (never both high)
//   pushData         address pushed on push
//   topData          current top entry, 0 when empty
//   full, empty      occupancy flags
//   err              pulse: push while full (dropped) or pop while empty
// ---------------------------------------------------------------------------
import cs_uarch_pkg::*;

module cs_seq_stack #(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] pushData,
   output logic [ADDR_W-1:0] topData,
   output logic              full,
   output logic              empty,
   output logic              err
);

   // Pointer counts 0..DEPTH, so it needs one more code than the index
   localparam int unsigned PTR_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  sp;

   assign full    = (sp == PTR_W'(DEPTH));
   assign empty   = (sp == '0);
   assign err     = (push & full) | (pop & empty);
   assign topData = empty ? '0 : mem[IDX_W'(sp - PTR_W'(1))];

   // Stack pointer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + PTR_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - PTR_W'(1);
      end
   end

   // Entry storage; contents above the pointer are don't-care
   always_ff @(posedge clock) begin
      if (push && !full) begin
         mem[IDX_W'(sp)] <= pushData;
      end
   end

endmodule

// File: rtl/cs_sequencer.sv
// ---------------------------------------------------------------------------
// cs_sequencer
// Microsequencer: owns the micro-program counter, evaluates COND against the
// ALU flags, stalls on memory and drives the MIR clear/load strobes.
// Optional macro CS_SEQ_STACK_EN enables the CALL/RET return stack; without
// it CALL acts as JMP, RET as NEXT and STACK_ERR reads 0.
// Ports:
//   CS_SEQ_CLOCK_50, CS_SEQ_RESET_InHigh   clock, async active-high reset
//   CS_SEQ_COND/ADDRESS/RD/WR_*            MIR fields
//   CS_SEQ_MEM_READY_InHigh                memory completes RD/WR this cycle
//   CS_SEQ_N_In, CS_SEQ_Z_In               ALU flags of this cycle
//   CS_SEQ_OPCODE_data_InBUS               macro opcode for DISPATCH
//   CS_SEQ_MPC_data_OutBUS                 control-store address (registered)
//   CS_SEQ_MIR_clear_OutLow                low: MIR loads NOP (combinational)
//   CS_SEQ_MIR_load_OutLow                 low: MIR holds (combinational)
//   CS_SEQ_HALTED_Out                      high while halted
//   CS_SEQ_STACK_ERR_Out                   sticky stack over/underflow
// ---------------------------------------------------------------------------
import cs_uarch_pkg::*;

module cs_sequencer #(
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                CS_SEQ_CLOCK_50,
   input  logic                CS_SEQ_RESET_InHigh,
   input  logic [COND_W-1:0]   CS_SEQ_COND_data_InBUS,
   input  logic [ADDR_W-1:0]   CS_SEQ_ADDRESS_data_InBUS,
   input  logic                CS_SEQ_RD_data_In,
   input  logic                CS_SEQ_WR_data_In,
   input  logic                CS_SEQ_MEM_READY_InHigh,
   input  logic                CS_SEQ_N_In,
   input  logic                CS_SEQ_Z_In,
   input  logic [OPCODE_W-1:0] CS_SEQ_OPCODE_data_InBUS,
   output logic [ADDR_W-1:0]   CS_SEQ_MPC_data_OutBUS,
   output logic                CS_SEQ_MIR_clear_OutLow,
   output logic                CS_SEQ_MIR_load_OutLow,
   output logic                CS_SEQ_HALTED_Out,
   output logic                CS_SEQ_STACK_ERR_Out
);

   mirSeqFieldsT      mir;
   logic [ADDR_W-1:0] mpcReg;
   logic [ADDR_W-1:0] mpcNext;
   logic [ADDR_W-1:0] mpcInc;
   stateE             stateReg;
   stateE             stateNext;
   logic              stall;
   logic              stackPush;
   logic              stackPop;

   assign mir.cond    = condE'(CS_SEQ_COND_data_InBUS);
   assign mir.address = CS_SEQ_ADDRESS_data_InBUS;
   assign mir.rd      = CS_SEQ_RD_data_In;
   assign mir.wr      = CS_SEQ_WR_data_In;

   assign stall  = (mir.rd | mir.wr) & ~CS_SEQ_MEM_READY_InHigh;
   assign mpcInc = mpcReg + ADDR_W'(1);

`ifdef CS_SEQ_STACK_EN
   logic [ADDR_W-1:0] stackTop;
   logic              stackFull;
   logic              stackEmpty;
   logic              stackErrPulse;
   logic              stackErrReg;

   cs_seq_stack #(
      .DEPTH (STACK_DEPTH)
   ) uStack (
      .clock    (CS_SEQ_CLOCK_50),
      .reset    (CS_SEQ_RESET_InHigh),
      .push     (stackPush),
      .pop      (stackPop),
      .pushData (mpcReg),
      .topData  (stackTop),
      .full     (stackFull),
      .empty    (stackEmpty),
      .err      (stackErrPulse)
   );

   // Sticky error; only reset clears it
   always_ff @(posedge CS_SEQ_CLOCK_50 or posedge CS_SEQ_RESET_InHigh) begin
      if (CS_SEQ_RESET_InHigh) begin
         stackErrReg <= 1'b0;
      end else if (stackErrPulse) begin
         stackErrReg <= 1'b1;
      end
   end

   assign CS_SEQ_STACK_ERR_Out = stackErrReg;
`else
   assign CS_SEQ_STACK_ERR_Out = 1'b0;
`endif

   // Next address, next state and MIR strobes
   always_comb begin
      mpcNext                 = mpcReg;
      stateNext               = stateReg;
      CS_SEQ_MIR_clear_OutLow = 1'b1;
      CS_SEQ_MIR_load_OutLow  = 1'b1;
      stackPush               = 1'b0;
      stackPop                = 1'b0;
      if (stateReg == ST_HALT) begin
         CS_SEQ_MIR_clear_OutLow = 1'b0;
      end else if (stall) begin
         // Hold MIR and MPC; COND is evaluated once memory is ready
         CS_SEQ_MIR_load_OutLow = 1'b0;
      end else begin
         case (mir.cond)
            COND_NEXT: mpcNext = mpcInc;
            COND_JN: begin
               mpcNext                 = CS_SEQ_N_In ? mir.address : mpcInc;
               CS_SEQ_MIR_clear_OutLow = ~CS_SEQ_N_In;
            end
            COND_JZ: begin
               mpcNext                 = CS_SEQ_Z_In ? mir.address : mpcInc;
               CS_SEQ_MIR_clear_OutLow = ~CS_SEQ_Z_In;
            end
            COND_JMP: begin
               mpcNext                 = mir.address;
               CS_SEQ_MIR_clear_OutLow = 1'b0;
            end
            COND_DISPATCH: begin
               mpcNext                 = dispatchTarget(mir.address, CS_SEQ_OPCODE_data_InBUS);
               CS_SEQ_MIR_clear_OutLow = 1'b0;
            end
            COND_CALL: begin
`ifdef CS_SEQ_STACK_EN
               stackPush               = 1'b1;
`endif
               mpcNext                 = mir.address;
               CS_SEQ_MIR_clear_OutLow = 1'b0;
            end
            COND_RET: begin
`ifdef CS_SEQ_STACK_EN
               // Underflow returns to address 0
               stackPop                = 1'b1;
               mpcNext                 = stackEmpty ? '0 : stackTop;
               CS_SEQ_MIR_clear_OutLow = 1'b0;
`else
               mpcNext                 = mpcInc;
`endif
            end
            COND_HALT: stateNext = ST_HALT;
            default:   mpcNext   = mpcInc;
         endcase
      end
   end

   // MPC and FSM state
   always_ff @(posedge CS_SEQ_CLOCK_50 or posedge CS_SEQ_RESET_InHigh) begin
      if (CS_SEQ_RESET_InHigh) begin
         mpcReg   <= '0;
         stateReg <= ST_RUN;
      end else begin
         mpcReg   <= mpcNext;
         stateReg <= stateNext;
      end
   end

   assign CS_SEQ_MPC_data_OutBUS = mpcReg;
   assign CS_SEQ_HALTED_Out      = (stateReg == ST_HALT);

   depthInRange: assert property (@(posedge CS_SEQ_CLOCK_50)
      (STACK_DEPTH >= 2) && (STACK_DEPTH <= 16));

   strobesNeverBothLow: assert property (@(posedge CS_SEQ_CLOCK_50)
      disable iff (CS_SEQ_RESET_InHigh)
      CS_SEQ_MIR_clear_OutLow || CS_SEQ_MIR_load_OutLow);

`ifndef CS_SEQ_STACK_EN
   // Stack request decodes exist only for the stack build
   logic unusedStack;
   assign unusedStack = stackPush | stackPop;
`endif

endmodule

// File: tb/tb_cs_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cs_sequencer
// Directed bench for cs_sequencer with a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_cs_sequencer;

   localparam int DEPTH = 4;
   localparam logic [2:0] C_NEXT = 3'd0, C_JN = 3'd1, C_JZ = 3'd2, C_JMP = 3'd3,
                          C_DISP = 3'd4, C_CALL = 3'd5, C_RET = 3'd6, C_HALT = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  cond = 3'd0;
   logic [10:0] addr = 11'd0;
   logic        rd = 1'b0, wr = 1'b0, rdy = 1'b0, fn = 1'b0, fz = 1'b0;
   logic [7:0]  op = 8'd0;

   logic [10:0] mpc;
   logic        clrLow, ldLow, halted, stkErr;

   int checks   = 0;
   int failures = 0;
   bit cmpEn    = 1'b0;

   // Reference model state
   int          mMpc    = 0;
   bit          mHalted = 1'b0;
   bit          mErr    = 1'b0;
   logic [10:0] mStk[$];

   cs_sequencer #(.STACK_DEPTH(DEPTH)) dut (
      .CS_SEQ_CLOCK_50           (clk),
      .CS_SEQ_RESET_InHigh       (rst),
      .CS_SEQ_COND_data_InBUS    (cond),
      .CS_SEQ_ADDRESS_data_InBUS (addr),
      .CS_SEQ_RD_data_In         (rd),
      .CS_SEQ_WR_data_In         (wr),
      .CS_SEQ_MEM_READY_InHigh   (rdy),
      .CS_SEQ_N_In               (fn),
      .CS_SEQ_Z_In               (fz),
      .CS_SEQ_OPCODE_data_InBUS  (op),
      .CS_SEQ_MPC_data_OutBUS    (mpc),
      .CS_SEQ_MIR_clear_OutLow   (clrLow),
      .CS_SEQ_MIR_load_OutLow    (ldLow),
      .CS_SEQ_HALTED_Out         (halted),
      .CS_SEQ_STACK_ERR_Out      (stkErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // What the sequencer must do this cycle, from the rules for each COND
   function automatic void evalModel(output int nxt, output bit clr, output bit ld,
                                     output bit toHalt, output bit doPush, output bit doPop);
      int inc;
      inc    = (mMpc + 1) % 2048;
      nxt    = mMpc;
      clr    = 1'b1;
      ld     = 1'b1;
      toHalt = 1'b0;
      doPush = 1'b0;
      doPop  = 1'b0;
      if (mHalted) begin
         clr = 1'b0;
      end else if ((rd || wr) && !rdy) begin
         ld = 1'b0;
      end else begin
         case (cond)
            C_NEXT: nxt = inc;
            C_JN:   begin nxt = fn ? int'(addr) : inc; clr = !fn; end
            C_JZ:   begin nxt = fz ? int'(addr) : inc; clr = !fz; end
            C_JMP:  begin nxt = int'(addr); clr = 1'b0; end
            C_DISP: begin nxt = (int'(addr) / 256) * 256 + int'(op); clr = 1'b0; end
            C_CALL: begin
`ifdef CS_SEQ_STACK_EN
               doPush = 1'b1;
`endif
               nxt = int'(addr); clr = 1'b0;
            end
            C_RET: begin
`ifdef CS_SEQ_STACK_EN
               doPop = 1'b1;
               clr   = 1'b0;
               nxt   = (mStk.size() == 0) ? 0 : int'(mStk[$]);
`else
               nxt = inc;
`endif
            end
            default: toHalt = 1'b1;
         endcase
      end
   endfunction

   // Model advance on each edge, with asynchronous reset
   always @(posedge clk or posedge rst) begin
      int  nxt;
      bit  clr, ld, toHalt, doPush, doPop;
      if (rst) begin
         mMpc    <= 0;
         mHalted <= 1'b0;
         mErr    <= 1'b0;
         mStk.delete();
      end else begin
         evalModel(nxt, clr, ld, toHalt, doPush, doPop);
         if (doPush) begin
            if (mStk.size() < DEPTH) mStk.push_back(11'(mMpc));
            else mErr <= 1'b1;
         end
         if (doPop) begin
            if (mStk.size() == 0) mErr <= 1'b1;
            else void'(mStk.pop_back());
         end
         mMpc    <= nxt;
         mHalted <= mHalted | toHalt;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      int nxt;
      bit clr, ld, toHalt, doPush, doPop;
      if (cmpEn) begin
         evalModel(nxt, clr, ld, toHalt, doPush, doPop);
         chk("model_mpc",    32'(mpc),    32'(mMpc));
         chk("model_halted", 32'(halted), 32'(mHalted));
         chk("model_err",    32'(stkErr), 32'(mErr));
         chk("model_clear",  32'(clrLow), 32'(clr));
         chk("model_load",   32'(ldLow),  32'(ld));
      end
   end

   task automatic setIn(input logic [2:0] c, input logic [10:0] a, input logic r, input logic w,
                        input logic m, input logic n, input logic z, input logic [7:0] o);
      cond = c; addr = a; rd = r; wr = w; rdy = m; fn = n; fz = z; op = o;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic jmpTo(input logic [10:0] a);
      setIn(C_JMP, a, 0, 0, 0, 0, 0, 8'd0);
      tick();
   endtask

   initial begin
      int expRet [5];
      setIn(C_NEXT, 11'd0, 0, 0, 0, 0, 0, 8'd0);
      @(posedge clk); #1;
      cmpEn = 1'b1;
      tick();
      chk("rst_mpc",    32'(mpc),    32'h000);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err",    32'(stkErr), 32'd0);
      chk("rst_clear",  32'(clrLow), 32'd1);
      chk("rst_load",   32'(ldLow),  32'd1);
      rst = 1'b0;

      // Sequential fetch
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("next_mpc", 32'(mpc), 32'(i));
      end
      chk("next_clear", 32'(clrLow), 32'd1);
      chk("next_load",  32'(ldLow),  32'd1);

      // JZ taken / not taken, JN taken / not taken
      jmpTo(11'h010);
      setIn(C_JZ, 11'h123, 0, 0, 0, 0, 1, 8'd0); #1;
      chk("jz_taken_clear", 32'(clrLow), 32'd0);
      tick(); chk("jz_taken_mpc", 32'(mpc), 32'h123);
      jmpTo(11'h010);
      setIn(C_JZ, 11'h123, 0, 0, 0, 0, 0, 8'd0); #1;
      chk("jz_fall_clear", 32'(clrLow), 32'd1);
      tick(); chk("jz_fall_mpc", 32'(mpc), 32'h011);
      setIn(C_JN, 11'h0AB, 0, 0, 0, 1, 0, 8'd0);
      tick(); chk("jn_taken_mpc", 32'(mpc), 32'h0AB);
      setIn(C_JN, 11'h0CD, 0, 0, 0, 0, 1, 8'd0);
      tick(); chk("jn_fall_mpc", 32'(mpc), 32'h0AC);

      // Memory stall for 3 cycles, then JMP in the ready cycle
      jmpTo(11'h020);
      setIn(C_JMP, 11'h050, 1, 0, 0, 0, 0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_load",  32'(ldLow),  32'd0);
         chk("stall_clear", 32'(clrLow), 32'd1);
         tick();
         chk("stall_mpc", 32'(mpc), 32'h020);
      end
      rdy = 1'b1; #1;
      chk("ready_clear", 32'(clrLow), 32'd0);
      chk("ready_load",  32'(ldLow),  32'd1);
      tick(); chk("ready_mpc", 32'(mpc), 32'h050);

      // Ready already high: no added cycle
      setIn(C_NEXT, 11'd0, 1, 0, 1, 0, 0, 8'd0); #1;
      chk("ready1_load", 32'(ldLow), 32'd1);
      tick(); chk("ready1_mpc", 32'(mpc), 32'h051);

      // Flags of the ready cycle decide the branch
      setIn(C_JZ, 11'h333, 0, 1, 0, 0, 1, 8'd0);
      tick(); chk("wrstall_mpc", 32'(mpc), 32'h051);
      setIn(C_JZ, 11'h333, 0, 1, 1, 0, 0, 8'd0);
      tick(); chk("wrready_mpc", 32'(mpc), 32'h052);

      // Dispatch keeps only ADDRESS[10:8]
      setIn(C_DISP, 11'h3FF, 0, 0, 0, 0, 0, 8'h2A);
      tick();
      chk("disp_mpc",   32'(mpc),  32'h32A);
      chk("disp_model", 32'(mMpc), 32'h32A);

      // 11-bit wrap
      jmpTo(11'h7FF);
      setIn(C_NEXT, 11'd0, 0, 0, 0, 0, 0, 8'd0);
      tick(); chk("wrap_mpc", 32'(mpc), 32'h000);

      // CALL then RET
      jmpTo(11'h041);
      setIn(C_CALL, 11'h200, 0, 0, 0, 0, 0, 8'd0);
      tick(); chk("call_mpc", 32'(mpc), 32'h200);
      setIn(C_RET, 11'h555, 0, 0, 0, 0, 0, 8'd0); #1;
`ifdef CS_SEQ_STACK_EN
      chk("ret_clear", 32'(clrLow), 32'd0);
      tick();
      chk("ret_mpc",   32'(mpc),  32'h041);
      chk("ret_model", 32'(mMpc), 32'h041);
`else
      chk("ret_clear", 32'(clrLow), 32'd1);
      tick();
      chk("ret_mpc",   32'(mpc),  32'h201);
      chk("ret_model", 32'(mMpc), 32'h201);
`endif

      // Five nested CALLs into a four-deep stack, then five RETs
      jmpTo(11'h041);
      for (int i = 0; i < 5; i++) begin
         setIn(C_CALL, 11'(32'h100 + i), 0, 0, 0, 0, 0, 8'd0);
         tick();
         chk("ncall_mpc", 32'(mpc), 32'h100 + 32'(i));
`ifdef CS_SEQ_STACK_EN
         chk("ncall_err", 32'(stkErr), (i == 4) ? 32'd1 : 32'd0);
`else
         chk("ncall_err", 32'(stkErr), 32'd0);
`endif
      end
`ifdef CS_SEQ_STACK_EN
      expRet = '{32'h102, 32'h101, 32'h100, 32'h041, 32'h000};
`else
      expRet = '{32'h105, 32'h106, 32'h107, 32'h108, 32'h109};
`endif
      for (int i = 0; i < 5; i++) begin
         setIn(C_RET, 11'h555, 0, 0, 0, 0, 0, 8'd0);
         tick();
         chk("nret_mpc", 32'(mpc), 32'(expRet[i]));
      end

      // Reset during a stall abandons the request
      setIn(C_NEXT, 11'd0, 1, 0, 0, 0, 0, 8'd0);
      tick();
      #3 rst = 1'b1; #1;
      chk("rststall_mpc", 32'(mpc),    32'h000);
      chk("rststall_err", 32'(stkErr), 32'd0);
      setIn(C_NEXT, 11'd0, 0, 0, 0, 0, 0, 8'd0);
      tick(); rst = 1'b0;
      tick(); chk("afterrst_mpc", 32'(mpc), 32'h001);

      // HALT requested during a stall takes effect only when ready
      jmpTo(11'h0A5);
      setIn(C_HALT, 11'd0, 1, 0, 0, 0, 0, 8'd0); #1;
      chk("haltstall_load", 32'(ldLow), 32'd0);
      tick();
      chk("haltstall_halted", 32'(halted), 32'd0);
      chk("haltstall_mpc",    32'(mpc),    32'h0A5);
      rdy = 1'b1;
      tick();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_mpc",    32'(mpc),    32'h0A5);
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) setIn(C_JMP, 11'h777, 0, 0, 0, 1, 1, 8'd0);
         else            setIn(C_RET, 11'h123, 1, 0, 0, 0, 0, 8'd0);
         #1;
         chk("inhalt_clear",  32'(clrLow), 32'd0);
         chk("inhalt_load",   32'(ldLow),  32'd1);
         chk("inhalt_halted", 32'(halted), 32'd1);
         tick();
         chk("inhalt_mpc", 32'(mpc), 32'h0A5);
      end
      #3 rst = 1'b1; #1;
      chk("rsthalt_mpc",    32'(mpc),    32'h000);
      chk("rsthalt_halted", 32'(halted), 32'd0);
      setIn(C_NEXT, 11'd0, 0, 0, 0, 0, 0, 8'd0);
      tick(); rst = 1'b0;
      tick(); chk("resume_mpc", 32'(mpc), 32'h001);

      @(posedge clk); #1;
      cmpEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cs_sequencer.md
# cs_sequencer

Microsequencer for the microprogrammed control unit: the consumer of the microinstruction register's COND, ADDRESS, RD and WR fields. It owns the micro-program counter (MPC) that addresses the asynchronous control store, evaluates branch conditions against the ALU flags, and stalls on memory. It drives the MIR's clear and load strobes to squash the fetched word after a taken transfer and to hold the MIR during memory waits.

## Interface
- STACK_DEPTH, 4: micro-return stack entries (2..16); used only with CS_SEQ_STACK_EN.
- CS_SEQ_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- CS_SEQ_RESET_InHigh  in  1  reset, asynchronous, active-high.
- CS_SEQ_COND_data_InBUS  in  3  MIR COND field.
- CS_SEQ_ADDRESS_data_InBUS  in  11  MIR ADDRESS field.
- CS_SEQ_RD_data_In / CS_SEQ_WR_data_In  in  1 each  MIR memory request bits.
- CS_SEQ_MEM_READY_InHigh  in  1  memory completes the current RD/WR this cycle.
- CS_SEQ_N_In / CS_SEQ_Z_In  in  1 each  ALU negative/zero flags for the current cycle.
- CS_SEQ_OPCODE_data_InBUS  in  8  macro-instruction opcode for dispatch.
- CS_SEQ_MPC_data_OutBUS  out  11  control-store address, registered.
- CS_SEQ_MIR_clear_OutLow  out  1  low: the MIR loads all-zeros (NOP) at the next edge.
- CS_SEQ_MIR_load_OutLow  out  1  low: the MIR holds its value at the next edge.
- CS_SEQ_HALTED_Out  out  1  high while in HALT.
- CS_SEQ_STACK_ERR_Out  out  1  sticky stack overflow/underflow flag.

## Operation
- COND encoding:
  - 0 NEXT: MPC+1.
  - 1 JN: ADDRESS if N, else MPC+1.
  - 2 JZ: ADDRESS if Z, else MPC+1.
  - 3 JMP: ADDRESS.
  - 4 DISPATCH: {ADDRESS[10:8], OPCODE}.
  - 5 CALL: push MPC, then target ADDRESS.
  - 6 RET: target is the popped value.
  - 7 HALT.
- MPC+1 is 11-bit modulo: 0x7FF -> 0x000.
- Taken transfer (JN/JZ taken, JMP, DISPATCH, CALL, RET): CS_SEQ_MIR_clear_OutLow=0 in that cycle, so the word fetched at the old MPC is squashed. No architectural delay slot.
- Stall condition: (RD|WR) & !MEM_READY.
  - load_OutLow=0; clear_OutLow=1; MPC holds.
  - COND is not evaluated, and no stack push or pop occurs.
  - The branch is evaluated in the MEM_READY cycle, using the flags of that cycle.
- FSM has two states, RUN and HALT.
  - COND=7 in RUN (not stalled) moves to HALT. MPC holds.
  - HALT: clear_OutLow=0 every cycle; load_OutLow=1; MPC frozen; HALTED=1.
  - Only reset leaves HALT.
- Stack behaviour (with CS_SEQ_STACK_EN):
  - Push when full: value dropped, STACK_ERR set, jump still taken.
  - Pop when empty: target 0x000, STACK_ERR set.
  - STACK_ERR clears only on reset.
- Reset values: MPC=0x000, state RUN, stack pointer 0, STACK_ERR=0, HALTED=0.
  - clear_OutLow and load_OutLow are combinational. With the MIR reset to zero they read 1,1.
- Reset mid-stall or in HALT: immediate return to the reset values. A pending memory request is abandoned.

## Timing
- MPC is registered. The next-address logic is combinational from the MIR fields, flags, OPCODE and MEM_READY.
- The MIR and MPC update on the same edge: the MIR captures CS[MPC], or NOP/hold per the strobes.
- Branch latency: a taken transfer evaluated in cycle k presents its target on MPC in cycle k+1. The target microinstruction is in the MIR in cycle k+2. Cycle k+1 executes a NOP.
- Stall: each cycle with RD|WR high and MEM_READY low adds exactly one cycle. A MEM_READY already high in the first cycle adds none.
- Strobe priority at the MIR: clear over load. The sequencer never drives both low.

## Configuration
- CS_SEQ_STACK_EN defined: a STACK_DEPTH-entry LIFO of 11-bit return addresses, with CALL/RET and STACK_ERR as above.
- Not defined: no stack storage.
  - COND=5 behaves exactly as JMP.
  - COND=6 behaves exactly as NEXT.
  - STACK_ERR is tied 0.

## Structure
- Shared package cs_uarch_pkg holds:
  - MIR field widths: ADDR=11, COND=3, OPCODE=8.
  - COND encodings: COND_NEXT..COND_HALT.
  - FSM state encodings: ST_RUN, ST_HALT.
- Sub-module cs_seq_stack: LIFO with push/pop/full/empty and an error pulse, instantiated only under CS_SEQ_STACK_EN.

## Test plan
- Reset then COND=0 for 3 cycles: MPC 0x000 -> 0x001 -> 0x002 -> 0x003; strobes stay 1,1.
- JZ to 0x123 with Z=1 at MPC=0x010: clear_OutLow=0 that cycle; next MPC=0x123. Repeat with Z=0: MPC=0x011 and no clear.
- RD=1 with MEM_READY low for 3 cycles, then high, COND=3 to 0x050:
  - load_OutLow=0 for 3 cycles, MPC frozen.
  - In the ready cycle, clear_OutLow=0; next MPC=0x050.
- DISPATCH with ADDRESS=0x300, OPCODE=0x2A: MPC=0x32A.
- CALL to 0x200 at MPC=0x041, then RET (macro on):
  - MPC goes to 0x200, then to 0x041.
  - 5 nested CALLs with depth 4 set STACK_ERR. RET on empty gives MPC=0x000.
  - With the macro off, CALL only jumps and RET gives MPC+1.
- COND=7: HALTED=1 and clear_OutLow=0 held for 10 cycles with MPC unchanged. Asserting reset mid-HALT gives MPC=0x000 and HALTED=0 asynchronously.
